vga_pixel_writer: RTL and testbench
===================================

VGA_PIXEL_WRITER -- requirements
Module: vga_pixel_writer

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: nrst, input, 1, reset; asynchronous, active-low.
REQ-003 The block SHALL have these ports: req, input, 1, pixel write request; sampled only while ready=1.
REQ-004 The block SHALL have these ports: x / y, input, 7 / 7, pixel column (0-127) / row (0-95).
REQ-005 The block SHALL have these ports: color, input, 1, pixel value to store.
REQ-006 The block SHALL have these ports: SRAM_busy, input, 1, SRAM cannot accept or complete an access.
REQ-007 The block SHALL have these ports: SRAM_data_in, input, 32, SRAM read data.
REQ-008 The block SHALL have these ports: word_address_dest, output, 32, SRAM word address.
REQ-009 The block SHALL have these ports: SRAM_data_out, output, 32, SRAM write data.
REQ-010 The block SHALL have these ports: byte_select, output, 4, SRAM byte enables.
REQ-011 The block SHALL have these ports: read_en / write_en, output, 1 / 1, SRAM read / write strobes.
REQ-012 The block SHALL have these ports: ready, output, 1, idle and able to accept req.
REQ-013 The block SHALL have these ports: done, output, 1, one-cycle pulse on write completion.
REQ-014 The block SHALL have these ports: err, output, 1, one-cycle pulse on rejected request.
REQ-015 The block SHALL have parameter FB_BASE, default 0, meaning framebuffer word base address; framebuffer is 128x96 pixels, 1 bit/pixel, 4 words per row, 384 words.

Function
REQ-016 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE; ready=1 only in IDLE.
REQ-017 In IDLE, req=1 SHALL capture x, y and color; y>=96 SHALL pulse err the next cycle and stay IDLE with no SRAM access; otherwise the FSM SHALL go to RD_REQ.
REQ-018 Address SHALL be FB_BASE + y*4 + x[6:5] (32-bit, wrap-around permitted); target bit index SHALL be x[4:0], with bit 0 the leftmost pixel of the word.
REQ-019 RD_REQ SHALL drive read_en=1 and byte_select=4'b1111, and hold them until a rising edge samples SRAM_busy=0, then go to RD_WAIT.
REQ-020 RD_WAIT SHALL capture SRAM_data_in on the first rising edge with SRAM_busy=0 and go to WR_REQ.
REQ-021 WR_REQ SHALL drive write_en=1 and SRAM_data_out = captured word with bit x[4:0] replaced by color; byte_select SHALL be the one-hot of x[4:3]; these SHALL be held until a rising edge samples SRAM_busy=0.
REQ-022 WR_WAIT SHALL wait for SRAM_busy=0 and then go to DONE; DONE SHALL pulse done for exactly one cycle and return to IDLE.
REQ-023 read_en and write_en SHALL never be high together; both SHALL be 0 outside their REQ states.
REQ-024 req asserted outside IDLE SHALL be ignored; there is no queuing.
REQ-025 Best-case latency from req accepted to done SHALL be 5 cycles with SRAM_busy held 0.

Reset
REQ-026 nrst=0 SHALL immediately force IDLE, ready=1, and set done, err, read_en, write_en, byte_select, SRAM_data_out and word_address_dest to 0, with captured registers cleared.
REQ-027 Reset mid-access SHALL abort the access; no write strobe SHALL follow deassertion.

Configuration
REQ-028 With VGA_PIXEL_WRITER_CLEAR_EN defined, the block SHALL add input clear (1 bit), sampled in IDLE with priority over req; it SHALL sweep words FB_BASE to FB_BASE+383 writing 0 with byte_select=4'b1111 through WR_REQ/WR_WAIT, skip reads, and pulse done once after word 383.
REQ-029 Without VGA_PIXEL_WRITER_CLEAR_EN, the clear port and sweep counter SHALL not exist; behaviour SHALL be otherwise identical.

Verification
REQ-030 The bench SHALL cover: reset, then check every output is 0, ready=1.
REQ-031 The bench SHALL cover: x=37, y=2, color=1, SRAM word 9 = 0 -> read word 9, write 0x00000020, byte_select=4'b0001, done at cycle 5.
REQ-032 The bench SHALL cover: y=96 -> err pulse only; read_en and write_en stay 0.
REQ-033 The bench SHALL cover: SRAM_busy high for 3 cycles during RD_REQ -> read_en held, address stable, done delayed by 3 cycles.
REQ-034 The bench SHALL cover: nrst low during WR_REQ -> write_en drops immediately and no write occurs after release.
REQ-035 The bench SHALL cover, with VGA_PIXEL_WRITER_CLEAR_EN defined: clear=1 -> 384 writes of 0 and a single done pulse.

Source files
------------

// File: rtl/vga_pixel_writer.sv
// ============================================================================
// Module      : vga_pixel_writer
// Description : Read-modify-write of single pixels in a 128x96 1 bpp SRAM
//               framebuffer. Optional full-screen clear sweep is enabled by
//               defining VGA_PIXEL_WRITER_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_writer #(
  parameter logic [31:0] FB_BASE = 32'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic        color,
  input  logic        SRAM_busy,
  input  logic [31:0] SRAM_data_in,
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
  input  logic        clear,
`endif
  output logic [31:0] word_address_dest,
  output logic [31:0] SRAM_data_out,
  output logic [3:0]  byte_select,
  output logic        read_en,
  output logic        write_en,
  output logic        ready,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [6:0] c_ROWS = 7'd96;

  state_t      r_state;
  logic [4:0]  r_bit;
  logic        r_color;

  logic [31:0] w_addr;
  logic        w_y_ok;
  logic [31:0] w_merged;
  logic [3:0]  w_wr_bs;
  logic        w_clear_go;
  logic        w_sweep_more;

  // Four 32-pixel words per row; x[6:5] picks the word, x[4:0] the pixel.
  assign w_addr   = FB_BASE + {23'd0, y, 2'b00} + {30'd0, x[6:5]};
  assign w_y_ok   = (y < c_ROWS);
  assign w_merged = (SRAM_data_in & ~(32'd1 << r_bit)) | ({31'd0, r_color} << r_bit);
  assign w_wr_bs  = 4'b0001 << r_bit[4:3];

`ifdef VGA_PIXEL_WRITER_CLEAR_EN
  localparam logic [8:0] c_LAST_WORD = 9'd383;

  logic       r_clearing;
  logic [8:0] r_sweep_cnt;

  assign w_clear_go   = clear;
  assign w_sweep_more = r_clearing && (r_sweep_cnt != c_LAST_WORD);
`else
  assign w_clear_go   = 1'b0;
  assign w_sweep_more = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state           <= IDLE;
      r_bit             <= 5'd0;
      r_color           <= 1'b0;
      word_address_dest <= 32'd0;
      SRAM_data_out     <= 32'd0;
      byte_select       <= 4'd0;
      read_en           <= 1'b0;
      write_en          <= 1'b0;
      ready             <= 1'b1;
      done              <= 1'b0;
      err               <= 1'b0;
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
      r_clearing        <= 1'b0;
      r_sweep_cnt       <= 9'd0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_clear_go) begin
            word_address_dest <= FB_BASE;
            SRAM_data_out     <= 32'd0;
            byte_select       <= 4'b1111;
            write_en          <= 1'b1;
            ready             <= 1'b0;
            r_state           <= WR_REQ;
          end else if (req) begin
            r_bit   <= x[4:0];
            r_color <= color;
            if (!w_y_ok) begin
              err <= 1'b1;
            end else begin
              word_address_dest <= w_addr;
              byte_select       <= 4'b1111;
              read_en           <= 1'b1;
              ready             <= 1'b0;
              r_state           <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!SRAM_busy) begin
            read_en     <= 1'b0;
            byte_select <= 4'd0;
            r_state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!SRAM_busy) begin
            SRAM_data_out <= w_merged;
            byte_select   <= w_wr_bs;
            write_en      <= 1'b1;
            r_state       <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!SRAM_busy) begin
            write_en    <= 1'b0;
            byte_select <= 4'd0;
            r_state     <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (!SRAM_busy) begin
            if (w_sweep_more) begin
              word_address_dest <= word_address_dest + 32'd1;
              SRAM_data_out     <= 32'd0;
              byte_select       <= 4'b1111;
              write_en          <= 1'b1;
              r_state           <= WR_REQ;
            end else begin
              done    <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          read_en  <= 1'b0;
          write_en <= 1'b0;
          ready    <= 1'b1;
          r_state  <= IDLE;
        end
      endcase

`ifdef VGA_PIXEL_WRITER_CLEAR_EN
      // Sweep bookkeeping tracks the word just completed in WR_WAIT.
      if (r_state == IDLE && clear) begin
        r_clearing  <= 1'b1;
        r_sweep_cnt <= 9'd0;
      end else if (r_state == WR_WAIT && !SRAM_busy && r_clearing) begin
        if (r_sweep_cnt == c_LAST_WORD)
          r_clearing <= 1'b0;
        else
          r_sweep_cnt <= r_sweep_cnt + 9'd1;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_writer.sv
// Testbench for vga_pixel_writer: SRAM model, vector table and corner sequences.
`default_nettype none

module tb_vga_pixel_writer;

  logic        tb_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req = 1'b0;
  logic [6:0]  x = 7'd0;
  logic [6:0]  y = 7'd0;
  logic        color = 1'b0;
  logic        SRAM_busy = 1'b0;
  logic [31:0] SRAM_data_in = 32'd0;
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
  logic        clear = 1'b0;
`endif
  logic [31:0] word_address_dest;
  logic [31:0] SRAM_data_out;
  logic [3:0]  byte_select;
  logic        read_en;
  logic        write_en;
  logic        ready;
  logic        done;
  logic        err;

  always #5 tb_clk = ~tb_clk;

  vga_pixel_writer #(.FB_BASE(32'd0)) dut (
    .clk               (tb_clk),
    .nrst              (nrst),
    .req               (req),
    .x                 (x),
    .y                 (y),
    .color             (color),
    .SRAM_busy         (SRAM_busy),
    .SRAM_data_in      (SRAM_data_in),
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
    .clear             (clear),
`endif
    .word_address_dest (word_address_dest),
    .SRAM_data_out     (SRAM_data_out),
    .byte_select       (byte_select),
    .read_en           (read_en),
    .write_en          (write_en),
    .ready             (ready),
    .done              (done),
    .err               (err)
  );

  // SRAM model: accepts a strobe on any edge with SRAM_busy low.
  logic [31:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = 9'd0;
  logic [31:0] pl_data = 32'd0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          overlap = 0;
  logic [31:0] last_rd_addr = 32'd0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;
  logic [3:0]  last_wr_bs = 4'd0;

  always @(posedge tb_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (read_en && !SRAM_busy) begin
      SRAM_data_in <= mem[word_address_dest[8:0]];
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= word_address_dest;
    end
    if (write_en && !SRAM_busy) begin
      for (int b = 0; b < 4; b++)
        if (byte_select[b])
          mem[word_address_dest[8:0]][8*b +: 8] <= SRAM_data_out[8*b +: 8];
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= word_address_dest;
      last_wr_data <= SRAM_data_out;
      last_wr_bs   <= byte_select;
    end
  end

  always @(negedge tb_clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (read_en && write_en) overlap <= overlap + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge tb_clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge tb_clk);
    pl_en = 1'b0;
  endtask

  // kind: 0 = timeout, 1 = done, 2 = err; lat counts negedges after the request edge
  task automatic run_req(input logic [6:0] xi, input logic [6:0] yi, input logic ci,
                         output int lat, output int kind);
    @(negedge tb_clk);
    x = xi; y = yi; color = ci; req = 1'b1;
    lat = 0; kind = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge tb_clk);
      req = 1'b0;
      if (done) begin lat = i; kind = 1; break; end
      if (err)  begin lat = i; kind = 2; break; end
    end
  endtask

  typedef struct packed {
    logic [6:0]  x;
    logic [6:0]  y;
    logic        c;
    logic [31:0] init;
    logic        is_err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bs;
    logic [31:0] fin;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, kind, rd0, wr0, er0, dn0;

    vecs[0] = '{7'd37,  7'd2,   1'b1, 32'h00000000, 1'b0, 32'd9,   32'h00000020, 4'b0001, 32'h00000020};
    vecs[1] = '{7'd0,   7'd0,   1'b1, 32'h00000000, 1'b0, 32'd0,   32'h00000001, 4'b0001, 32'h00000001};
    vecs[2] = '{7'd127, 7'd95,  1'b1, 32'h00000000, 1'b0, 32'd383, 32'h80000000, 4'b1000, 32'h80000000};
    vecs[3] = '{7'd70,  7'd10,  1'b0, 32'hFFFFFFFF, 1'b0, 32'd42,  32'hFFFFFFBF, 4'b0001, 32'hFFFFFFBF};
    vecs[4] = '{7'd45,  7'd50,  1'b1, 32'h12345678, 1'b0, 32'd201, 32'h12347678, 4'b0010, 32'h12347678};
    vecs[5] = '{7'd5,   7'd96,  1'b1, 32'h00000000, 1'b1, 32'd0,   32'h00000000, 4'b0000, 32'h00000000};
    vecs[6] = '{7'd127, 7'd127, 1'b0, 32'h00000000, 1'b1, 32'd0,   32'h00000000, 4'b0000, 32'h00000000};
    vecs[7] = '{7'd24,  7'd1,   1'b0, 32'h01000000, 1'b0, 32'd4,   32'h00000000, 4'b1000, 32'h00000000};

    // Reset state
    repeat (3) @(negedge tb_clk);
    chk("rst_addr", word_address_dest, 32'd0);
    chk("rst_wdata", SRAM_data_out, 32'd0);
    chk("rst_bs", {28'd0, byte_select}, 32'd0);
    chk("rst_rd_en", {31'd0, read_en}, 32'd0);
    chk("rst_wr_en", {31'd0, write_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    nrst = 1'b1;
    @(negedge tb_clk);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      if (!vecs[v].is_err) preload(vecs[v].addr[8:0], vecs[v].init);
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_req(vecs[v].x, vecs[v].y, vecs[v].c, lat, kind);
      if (vecs[v].is_err) begin
        chk($sformatf("v%0d_kind", v), kind, 2);
        chk($sformatf("v%0d_lat", v), lat, 1);
        chk($sformatf("v%0d_ready", v), {31'd0, ready}, 32'd1);
        @(negedge tb_clk);
        chk($sformatf("v%0d_err_width", v), {31'd0, err}, 32'd0);
        chk($sformatf("v%0d_reads", v), rd_cnt - rd0, 0);
        chk($sformatf("v%0d_writes", v), wr_cnt - wr0, 0);
      end else begin
        chk($sformatf("v%0d_kind", v), kind, 1);
        chk($sformatf("v%0d_lat", v), lat, 5);
        chk($sformatf("v%0d_rd_addr", v), last_rd_addr, vecs[v].addr);
        chk($sformatf("v%0d_wr_addr", v), last_wr_addr, vecs[v].addr);
        chk($sformatf("v%0d_wr_data", v), last_wr_data, vecs[v].data);
        chk($sformatf("v%0d_wr_bs", v), {28'd0, last_wr_bs}, {28'd0, vecs[v].bs});
        chk($sformatf("v%0d_mem", v), mem[vecs[v].addr[8:0]], vecs[v].fin);
        chk($sformatf("v%0d_reads", v), rd_cnt - rd0, 1);
        chk($sformatf("v%0d_writes", v), wr_cnt - wr0, 1);
        @(negedge tb_clk);
        chk($sformatf("v%0d_done_width", v), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_ready", v), {31'd0, ready}, 32'd1);
      end
    end

    // SRAM busy for 3 cycles during RD_REQ; req with bad y meanwhile must be ignored
    preload(9'd9, 32'd0);
    er0 = err_cnt; rd0 = rd_cnt;
    @(negedge tb_clk);
    x = 7'd37; y = 7'd2; color = 1'b1; req = 1'b1;
    @(negedge tb_clk);
    req = 1'b0; SRAM_busy = 1'b1;
    chk("stall_rd_en_0", {31'd0, read_en}, 32'd1);
    y = 7'd96; req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge tb_clk);
      chk($sformatf("stall_rd_en_%0d", k), {31'd0, read_en}, 32'd1);
      chk($sformatf("stall_addr_%0d", k), word_address_dest, 32'd9);
      chk($sformatf("stall_bs_%0d", k), {28'd0, byte_select}, 32'hF);
    end
    SRAM_busy = 1'b0; req = 1'b0;
    lat = 0;
    for (int i = 5; i <= 60; i++) begin
      @(negedge tb_clk);
      if (done) begin lat = i; break; end
    end
    chk("stall_lat", lat, 8);
    repeat (2) @(negedge tb_clk);
    chk("stall_mem", mem[9], 32'h20);
    chk("stall_no_err", err_cnt - er0, 0);
    chk("stall_reads", rd_cnt - rd0, 1);

    // Reset asserted while write strobe is up
    preload(9'd4, 32'h55555555);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge tb_clk);
    x = 7'd24; y = 7'd1; color = 1'b1; req = 1'b1;
    @(negedge tb_clk);
    req = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    chk("abort_wr_en_before", {31'd0, write_en}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("abort_wr_en_now", {31'd0, write_en}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_bs", {28'd0, byte_select}, 32'd0);
    chk("abort_addr", word_address_dest, 32'd0);
    chk("abort_wdata", SRAM_data_out, 32'd0);
    @(negedge tb_clk);
    nrst = 1'b1;
    repeat (10) @(negedge tb_clk);
    chk("abort_writes", wr_cnt - wr0, 0);
    chk("abort_reads", rd_cnt - rd0, 1);
    chk("abort_mem", mem[4], 32'h55555555);
    chk("abort_no_done", done_cnt - dn0, 0);

`ifdef VGA_PIXEL_WRITER_CLEAR_EN
    preload(9'd0, 32'hFFFFFFFF);
    preload(9'd200, 32'h12345678);
    preload(9'd383, 32'hFFFFFFFF);
    preload(9'd384, 32'h0000ABCD);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge tb_clk);
    clear = 1'b1;
    @(negedge tb_clk);
    clear = 1'b0;
    kind = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge tb_clk);
      if (done) begin kind = 1; break; end
    end
    chk("clr_done_seen", kind, 1);
    repeat (5) @(negedge tb_clk);
    chk("clr_writes", wr_cnt - wr0, 384);
    chk("clr_reads", rd_cnt - rd0, 0);
    chk("clr_done_once", done_cnt - dn0, 1);
    chk("clr_last_addr", last_wr_addr, 32'd383);
    chk("clr_last_bs", {28'd0, last_wr_bs}, 32'hF);
    chk("clr_mem0", mem[0], 32'd0);
    chk("clr_mem200", mem[200], 32'd0);
    chk("clr_mem383", mem[383], 32'd0);
    chk("clr_mem384", mem[384], 32'h0000ABCD);
`endif

    chk("rd_wr_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
